// File: rtl/instr_fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: error codes, FSM
// states, default NOP word and the request address classifier.
package cpu_fetch_pkg;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misalignment wins over range; upper address bits are never wrapped.
  function automatic logic [1:0] classify_addr(input logic [31:0] addr,
                                               input int unsigned depth_words);
    logic [63:0] limit;
    limit = 64'(depth_words) * 64'd4;
    if (addr[1:0] != 2'b00)
      return ERR_MISALIGN;
    else if ({32'h0, addr} >= limit)
      return ERR_RANGE;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response handshake bundle between the fetch stage (master)
// and the instruction responder (slave).
interface instr_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_err
  );
endinterface

// File: rtl/instr_fetch_responder_mem.sv
// Instruction memory: one write port and one synchronous read port; a read
// and write of the same word on the same edge returns the old contents.
module instr_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WIDTH       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
  output logic [WIDTH-1:0]               rd_data
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder end of the CPU instruction-fetch interface: accepts a PC, waits
// WAIT_STATES cycles and returns the instruction word or an error response.
module instr_fetch_responder
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  instr_fetch_responder_if.slave         fetch,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic                           busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [1:0]    err_q, err_nx;
  logic [AW-1:0] idx_q, idx_nx;
  logic [1:0]    req_err;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;

  assign req_err = classify_addr(fetch.req_addr, DEPTH_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err_q <= ERR_OK;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
      idx_q <= idx_nx;
    end
  end

  // The array read fires on whichever edge enters RESP, so with no wait
  // states the index comes straight from the request bus.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err_q;
    idx_nx   = idx_q;
    rd_en    = 1'b0;
    rd_idx   = idx_q;
    unique case (state)
      ST_IDLE: begin
        if (fetch.req_valid) begin
          idx_nx = fetch.req_addr[2 +: AW];
          err_nx = req_err;
          if (req_err != ERR_OK || WAIT_STATES == 0) begin
            state_nx = ST_RESP;
            rd_en    = (req_err == ERR_OK);
            rd_idx   = fetch.req_addr[2 +: AW];
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = 4'(WAIT_STATES) - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = ST_RESP;
          rd_en    = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (fetch.resp_ready)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (32)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  assign fetch.req_ready  = (state == ST_IDLE);
  assign fetch.resp_valid = (state == ST_RESP);
  assign fetch.resp_err   = err_q;
  assign fetch.resp_instr = (err_q == ERR_OK) ? rd_data : NOP_INSTR;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: one instance with two wait
// states and one with none, sharing clock and reset.
module tb_instr_fetch_responder;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_responder_if f2 ();
  instr_fetch_responder_if f0 ();

  logic       ld2_en, ld0_en;
  logic [7:0] ld2_addr, ld0_addr;
  logic [31:0] ld2_data, ld0_data;
  logic       busy2, busy0;

  instr_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .NOP_INSTR(32'h0000_0013)) dut2 (
    .clk(clk), .reset(reset), .fetch(f2), .load_en(ld2_en),
    .load_addr(ld2_addr), .load_data(ld2_data), .busy(busy2)
  );

  instr_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .NOP_INSTR(32'h0000_0013)) dut0 (
    .clk(clk), .reset(reset), .fetch(f0), .load_en(ld0_en),
    .load_addr(ld0_addr), .load_data(ld0_data), .busy(busy0)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  resp_t q2[$];
  resp_t q0[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: compare each response at the cycle it is consumed.
  initial forever begin
    @(negedge clk);
    if (reset && f2.resp_valid && f2.resp_ready) begin
      if (q2.size() == 0) check_eq("dut2_unexpected_resp", 32'd1, 32'd0);
      else begin
        resp_t e;
        e = q2.pop_front();
        check_eq("dut2_instr", f2.resp_instr, e.instr);
        check_eq("dut2_err", 32'(f2.resp_err), 32'(e.err));
      end
    end
  end

  int last_resp0 = -1;
  initial forever begin
    @(negedge clk);
    if (reset && f0.resp_valid && f0.resp_ready) begin
      if (last_resp0 >= 0) check_eq("dut0_resp_spacing", 32'(cyc - last_resp0), 32'd2);
      last_resp0 = cyc;
      if (q0.size() == 0) check_eq("dut0_unexpected_resp", 32'd1, 32'd0);
      else begin
        resp_t e;
        e = q0.pop_front();
        check_eq("dut0_instr", f0.resp_instr, e.instr);
        check_eq("dut0_err", 32'(f0.resp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic load2(input logic [7:0] idx, input logic [31:0] data);
    ld2_en = 1'b1; ld2_addr = idx; ld2_data = data;
    @(posedge clk); #1;
    ld2_en = 1'b0;
  endtask

  task automatic load0(input logic [7:0] idx, input logic [31:0] data);
    ld0_en = 1'b1; ld0_addr = idx; ld0_data = data;
    @(posedge clk); #1;
    ld0_en = 1'b0;
  endtask

  task automatic wait_ready2();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (f2.req_ready) return;
    end
    check_eq("dut2_req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp2(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (f2.resp_valid) return;
    end
    check_eq("dut2_resp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch2(input logic [31:0] addr, input logic [31:0] ei,
                        input logic [1:0] ee, input int exp_lat);
    int lat;
    q2.push_back(resp_t'{instr: ei, err: ee});
    f2.req_addr = addr; f2.req_valid = 1'b1;
    wait_ready2();
    @(posedge clk); #1;
    f2.req_valid = 1'b0;
    wait_resp2(lat);
    check_eq($sformatf("dut2_latency_%h", addr), 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    f2.req_valid = 1'b0; f2.req_addr = '0; f2.resp_ready = 1'b1;
    f0.req_valid = 1'b0; f0.req_addr = '0; f0.resp_ready = 1'b1;
    ld2_en = 1'b0; ld2_addr = '0; ld2_data = '0;
    ld0_en = 1'b0; ld0_addr = '0; ld0_data = '0;
    #12;
    check_eq("rst_req_ready", 32'(f2.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(f2.resp_valid), 32'd0);
    check_eq("rst_resp_instr", f2.resp_instr, 32'h0);
    check_eq("rst_resp_err", 32'(f2.resp_err), 32'd0);
    check_eq("rst_busy", 32'(busy2), 32'd0);
    check_eq("rst_dut0_busy", 32'(busy0), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    load2(8'd0, 32'hA5A5_0000);
    load2(8'd1, 32'hDEAD_BEEF);
    load2(8'd2, 32'h2222_2222);
    load2(8'd255, 32'hCAFE_F00D);

    fetch2(32'h0000_0004, 32'hDEAD_BEEF, 2'b00, 3);
    fetch2(32'h0000_0006, 32'h0000_0013, 2'b01, 1);
    fetch2(32'h0000_0400, 32'h0000_0013, 2'b10, 1);
    fetch2(32'h0000_0402, 32'h0000_0013, 2'b01, 1);
    fetch2(32'h0000_03FC, 32'hCAFE_F00D, 2'b00, 3);
    fetch2(32'hFFFF_FFFC, 32'h0000_0013, 2'b10, 1);

    // Backpressure with a second request waiting behind the first.
    q2.push_back(resp_t'{instr: 32'hA5A5_0000, err: 2'b00});
    q2.push_back(resp_t'{instr: 32'h2222_2222, err: 2'b00});
    f2.resp_ready = 1'b0;
    f2.req_addr = 32'h0; f2.req_valid = 1'b1;
    wait_ready2();
    @(posedge clk); #1;
    f2.req_addr = 32'h8;
    wait_resp2(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_resp_valid", 32'(f2.resp_valid), 32'd1);
      check_eq("bp_resp_instr", f2.resp_instr, 32'hA5A5_0000);
      check_eq("bp_req_ready", 32'(f2.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    f2.resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_ready_after_hs", 32'(f2.req_ready), 32'd1);
    @(posedge clk); #1;
    f2.req_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_accepted", 32'(busy2), 32'd1);
    wait_resp2(lat);
    @(posedge clk); #1;

    // Load lands on the RESP-entry edge of a fetch to the same word.
    q2.push_back(resp_t'{instr: 32'h2222_2222, err: 2'b00});
    f2.req_addr = 32'h8; f2.req_valid = 1'b1;
    wait_ready2();
    @(posedge clk); #1;
    f2.req_valid = 1'b0;
    @(posedge clk); #1;
    ld2_en = 1'b1; ld2_addr = 8'd2; ld2_data = 32'h1111_1111;
    @(posedge clk); #1;
    ld2_en = 1'b0;
    @(negedge clk);
    check_eq("collide_resp_valid", 32'(f2.resp_valid), 32'd1);
    @(posedge clk); #1;
    fetch2(32'h0000_0008, 32'h1111_1111, 2'b00, 3);

    // Reset in the middle of WAIT drops the request.
    f2.req_addr = 32'h4; f2.req_valid = 1'b1;
    wait_ready2();
    @(posedge clk); #1;
    f2.req_valid = 1'b0;
    #1;
    check_eq("midwait_busy", 32'(busy2), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_resp_valid", 32'(f2.resp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(f2.req_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy2), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    fetch2(32'h0000_0000, 32'hA5A5_0000, 2'b00, 3);

    // Zero wait states: back-to-back fetches, one response every 2 cycles.
    load0(8'd0, 32'h1000_0001);
    load0(8'd1, 32'h2000_0002);
    load0(8'd2, 32'h3000_0003);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ev;
      ev = (i == 0) ? 32'h1000_0001 : (i == 1) ? 32'h2000_0002 : 32'h3000_0003;
      q0.push_back(resp_t'{instr: ev, err: 2'b00});
      f0.req_addr = 32'(i * 4); f0.req_valid = 1'b1;
      begin : wait0
        for (int j = 0; j < 50; j++) begin
          @(negedge clk);
          if (f0.req_ready) disable wait0;
        end
        check_eq("dut0_req_ready_timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
    end
    f0.req_valid = 1'b0;
    for (int j = 0; j < 20 && (q0.size() != 0 || q2.size() != 0); j++) @(posedge clk);
    @(negedge clk);
    check_eq("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check_eq("dut2_queue_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
